dpram_fifo_ctrl: RTL and testbench
==================================

# dpram_fifo_ctrl

Sequences the 64 x 64-bit dual-port RAM (`dpram`) as a circular block FIFO between the host loader and the DES round engine. Port 0 is the write port, fed by a valid/ready input stream of 64-bit DES blocks. Port 1 is the read port; it delivers blocks to the engine through a valid/ready output stream with zero-bubble prefetch. It owns all RAM address, enable and write-strobe generation, and reports occupancy.

## Interface
- `DW`, 64, block width (matches `dpram` data width)
- `AW`, 6, RAM address width
- `DEPTH`, 64, entries; must equal 2**AW
- `clk` in 1, single clock, rising edge
- `rst` in 1, synchronous, active-high reset
- `in_valid` in 1, host offers a block
- `in_ready` out 1, controller accepts (= !full)
- `in_data` in DW, block to store
- `out_valid` out 1, block available to engine
- `out_ready` in 1, engine consumes
- `out_data` out DW, block presented
- `count` out AW+1, blocks stored and not yet consumed (0..DEPTH)
- `full` out 1, count == DEPTH
- `empty` out 1, count == 0
- `mem_en` out 1, to `dpram.en`; high in any cycle with a port access
- `mem_wr0` out 1, port-0 write strobe (1 = write)
- `mem_add0` out AW, port-0 address
- `mem_data0_in` out DW, port-0 write data
- `mem_wr1` out 1, tied 0 (port 1 is read-only)
- `mem_add1` out AW, port-1 address
- `mem_data1_in` out DW, tied 0
- `mem_data1_out` in DW, port-1 read data, valid 1 cycle after address/en
- `flush` in 1, present only with `DPRAM_FIFO_FLUSH_EN`

## Operation
- Push: `in_valid & in_ready` in cycle N drives `mem_wr0=1`, `mem_add0=wr_ptr`, `mem_data0_in=in_data`, `mem_en=1`. `wr_ptr` increments mod DEPTH at the N edge.
- `avail` = written but not yet fetched entries (0..DEPTH). A write makes an entry fetchable from cycle N+1; there is no same-cycle bypass.
- Fetch: drives `mem_add1=rd_ptr`, `mem_en=1`; `rd_ptr` increments mod DEPTH and `avail` decrements.
- Read FSM:
  - IDLE: `out_valid=0`. If `avail>0`, fetch and go to FETCH.
  - FETCH: `out_valid=1`, `out_data=mem_data1_out`; data is also captured into `hold_q`.
    - If `out_ready` and `avail>0`: fetch, stay in FETCH.
    - If `out_ready` and `avail==0`: go to IDLE.
    - If `!out_ready`: go to VALID.
  - VALID: `out_valid=1`, `out_data=hold_q`.
    - If `out_ready`: fetch if `avail>0` and go to FETCH, else go to IDLE.
- `count` increments on push and decrements on pop (`out_valid & out_ready`). On a simultaneous push and pop it is unchanged.
- `full`, `empty` and `in_ready` are decoded from registered `count`.
- Read and write addresses never collide: a fetch only targets written entries, and a write only targets free entries.

## Timing
- Reset (one `clk` edge with `rst=1`):
  - Pointers, `count` and `avail` = 0; FSM = IDLE.
  - `out_valid=0`, `in_ready=1`, `empty=1`, `full=0`, `out_data`/`hold_q`=0.
  - All `mem_*` strobes 0.
- `rst` mid-transfer drops in-flight blocks; RAM contents are not cleared.
- Latency from push into an empty FIFO to `out_valid`: 2 cycles (push at N, fetch at N+1, valid at N+2).
- Sustained throughput is 1 block/cycle, with no bubble while `avail>0` and `out_ready=1`.
- Full: `in_ready=0`, and `in_valid` is ignored. A pop in the same cycle raises `in_ready` next cycle; there is no same-cycle pass-through.
- Pointer wrap 63→0 is seamless.

## Configuration
- `DPRAM_FIFO_FLUSH_EN` defined:
  - Adds the `flush` input.
  - `flush=1` at an edge: pointers, `count` and `avail` reset to 0 and the FSM goes to IDLE. Any push or pop in that cycle is discarded.
  - `out_valid=0` and `in_ready=1` from the next cycle.
  - `rst` has priority over `flush`.
- Undefined: no `flush` port, and no flush logic is generated.

## Structure
- Shared package `des_mem_pkg`:
  - `DES_BLK_W=64`, `DPRAM_AW=6`.
  - FSM enum `rd_state_t {RD_IDLE, RD_FETCH, RD_VALID}`.
- One natural sub-module: `fifo_rd_stage` (the read FSM plus `hold_q` and output mux). Pointer and count logic stay in the top level.

## Test plan
- Reset → `count=0`, `empty=1`, `in_ready=1`, `out_valid=0`, `mem_en=0`.
- Push 64'h0123456789ABCDEF, then 64'hFEDCBA9876543210, with `out_ready=1` → `out_valid` at cycle 2. Blocks emerge in order on consecutive cycles; `count` returns to 0.
- Push 64 random blocks with `out_ready=0` → `full=1` and `in_ready=0`. A 65th `in_valid` is ignored; `count` stays 64.
- Full FIFO, `out_ready=1`, continuous `in_valid` for 200 cycles → one pop and one push per cycle after startup; data matches the reference queue across the 63→0 wrap.
- `out_ready` toggled 1,0,0,1 mid-stream → `out_data` is held stable while stalled; no block is lost or duplicated.
- With `DPRAM_FIFO_FLUSH_EN`: flush at `count=10` → next cycle `count=0`, `empty=1`, `out_valid=0`. A subsequent push of 64'h1 appears as the first output.

Source files
------------

// File: rtl/des_mem_pkg.sv
// Shared definitions for the DES block memory path: widths and the read-stage FSM encoding.
package des_mem_pkg;
  localparam int DES_BLK_W = 64;
  localparam int DPRAM_AW  = 6;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_VALID = 2'd2
  } rd_state_t;
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Block streams around the FIFO controller: host->FIFO input stream and FIFO->engine output stream.
interface dpram_fifo_ctrl_if #(parameter int DW = 64);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/dpram_fifo_ctrl_rd_stage.sv
// fifo_rd_stage: read FSM for the dpram port 1; prefetches one block and skid-holds it while the engine stalls.
module fifo_rd_stage
  import des_mem_pkg::*;
#(
  parameter int DW = DES_BLK_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          avail_nz,
  input  logic          out_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          fetch,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  rd_state_t     state;
  logic [DW-1:0] hold_q;

  // A fetch is issued whenever the slot after the current one is free next cycle.
  assign fetch    = avail_nz & ((state == RD_IDLE) | out_ready) & ~clr;
  assign out_data = (state == RD_FETCH) ? mem_rdata : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      out_valid <= 1'b0;
      hold_q    <= '0;
    end else if (clr) begin
      state     <= RD_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (avail_nz) begin
            state     <= RD_FETCH;
            out_valid <= 1'b1;
          end
        end
        RD_FETCH: begin
          hold_q <= mem_rdata;
          if (!out_ready) begin
            state <= RD_VALID;
          end else if (!avail_nz) begin
            state     <= RD_IDLE;
            out_valid <= 1'b0;
          end
        end
        RD_VALID: begin
          if (out_ready) begin
            if (avail_nz) begin
              state <= RD_FETCH;
            end else begin
              state     <= RD_IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= RD_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Circular block FIFO sequencer over the 64x64 dual-port RAM: port 0 writes, port 1 prefetches.
// Optional DPRAM_FIFO_FLUSH_EN adds a synchronous flush input.
module dpram_fifo_ctrl
  import des_mem_pkg::*;
#(
  parameter int DW    = DES_BLK_W,
  parameter int AW    = DPRAM_AW,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
`ifdef DPRAM_FIFO_FLUSH_EN
  input  logic          flush,
`endif
  dpram_fifo_ctrl_if.slave s,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          mem_en,
  output logic          mem_wr0,
  output logic [AW-1:0] mem_add0,
  output logic [DW-1:0] mem_data0_in,
  output logic          mem_wr1,
  output logic [AW-1:0] mem_add1,
  output logic [DW-1:0] mem_data1_in,
  input  logic [DW-1:0] mem_data1_out
);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   avail;
  logic          clr, push, pop, fetch;

`ifdef DPRAM_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign full       = (count == FULLC);
  assign empty      = (count == '0);
  assign s.in_ready = ~full;

  assign push = s.in_valid & s.in_ready & ~clr;
  assign pop  = s.out_valid & s.out_ready & ~clr;

  assign mem_en       = push | fetch;
  assign mem_wr0      = push;
  assign mem_add0     = wr_ptr;
  assign mem_data0_in = push ? s.in_data : '0;
  assign mem_wr1      = 1'b0;
  assign mem_add1     = rd_ptr;
  assign mem_data1_in = '0;

  fifo_rd_stage #(.DW(DW)) u_rd (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .avail_nz  (avail != '0),
    .out_ready (s.out_ready),
    .mem_rdata (mem_data1_out),
    .fetch     (fetch),
    .out_valid (s.out_valid),
    .out_data  (s.out_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      avail  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      case ({push, fetch})
        2'b10:   avail <= avail + ONE;
        2'b01:   avail <= avail - ONE;
        default: avail <= avail;
      endcase
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural dpram, scoreboard queue of accepted blocks, negedge monitor.
module tb_dpram_fifo_ctrl;
  localparam int DW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
`ifdef DPRAM_FIFO_FLUSH_EN
  logic          flush;
`endif
  logic [AW:0]   count;
  logic          full, empty, mem_en, mem_wr0, mem_wr1;
  logic [AW-1:0] mem_add0, mem_add1;
  logic [DW-1:0] mem_data0_in, mem_data1_in, mem_data1_out;

  dpram_fifo_ctrl_if #(.DW(DW)) sif ();

  dpram_fifo_ctrl dut (
    .clk           (clk),
    .rst           (rst),
`ifdef DPRAM_FIFO_FLUSH_EN
    .flush         (flush),
`endif
    .s             (sif),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .mem_en        (mem_en),
    .mem_wr0       (mem_wr0),
    .mem_add0      (mem_add0),
    .mem_data0_in  (mem_data0_in),
    .mem_wr1       (mem_wr1),
    .mem_add1      (mem_add1),
    .mem_data1_in  (mem_data1_in),
    .mem_data1_out (mem_data1_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr0) ram[mem_add0] <= mem_data0_in;
      mem_data1_out <= ram[mem_add1];
    end
  end

  logic [DW-1:0] sb_q[$];
  int mon_checks = 0, mon_fail = 0, pops = 0;
  int dir_checks = 0, dir_fail = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  // Monitor: record accepted pushes, compare every pop, and check hold stability during stalls.
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.in_valid && sif.in_ready) sb_q.push_back(sif.in_data);
      if (sif.out_valid && prev_stall) begin
        mon_checks++;
        if (sif.out_data !== prev_data) begin
          mon_fail++;
          $display("FAIL stall_hold: got %h required %h", sif.out_data, prev_data);
        end
      end
      if (sif.out_valid && sif.out_ready) begin
        mon_checks++;
        pops++;
        if (sb_q.size() == 0) begin
          mon_fail++;
          $display("FAIL pop_data: got %h required none (queue empty)", sif.out_data);
        end else begin
          logic [DW-1:0] e;
          e = sb_q.pop_front();
          if (sif.out_data !== e) begin
            mon_fail++;
            $display("FAIL pop_data: got %h required %h", sif.out_data, e);
          end
        end
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    dir_checks++;
    if (got !== req) begin
      dir_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    sif.out_ready = 1'b0;
`ifdef DPRAM_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(sif.in_ready), 64'd1);
    chk("rst_out_valid", 64'(sif.out_valid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);

    // Two-block latency test.
    sif.out_ready = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_data = 64'h0123456789ABCDEF;
    step();
    chk("lat_n1_out_valid", 64'(sif.out_valid), 64'd0);
    sif.in_data = 64'hFEDCBA9876543210;
    step();
    chk("lat_n2_out_valid", 64'(sif.out_valid), 64'd1);
    sif.in_valid = 1'b0;
    step();
    chk("lat_n3_out_valid", 64'(sif.out_valid), 64'd1);
    step();
    chk("lat_n4_out_valid", 64'(sif.out_valid), 64'd0);
    chk("lat_count0", 64'(count), 64'd0);

    // Fill to full with the engine stalled.
    sif.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = {$urandom, $urandom};
      step();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(sif.in_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd64);
    sif.in_data = 64'hDEADDEADDEADDEAD;
    step();
    chk("overflow_count", 64'(count), 64'd64);

    // Streaming through a full FIFO across pointer wrap.
    p0 = pops;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sif.in_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      step();
    end
    chk("stream_pops", 64'(pops - p0), 64'd200);
    chk("stream_count", 64'(count), 64'd63);

    // Drain with a 1,0,0,1 ready pattern.
    sif.in_valid = 1'b0;
    for (int i = 0; i < 400 && !(empty && !sif.out_valid); i++) begin
      sif.out_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);

`ifdef DPRAM_FIFO_FLUSH_EN
    sif.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = 64'h100 + 64'(i);
      step();
    end
    sif.in_valid = 1'b0;
    chk("pre_flush_count", 64'(count), 64'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb_q.delete();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_out_valid", 64'(sif.out_valid), 64'd0);
    chk("flush_in_ready", 64'(sif.in_ready), 64'd1);
    p0 = pops;
    sif.out_ready = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_data = 64'h1;
    step();
    sif.in_valid = 1'b0;
    step(); step(); step();
    chk("post_flush_pops", 64'(pops - p0), 64'd1);
    chk("post_flush_sb_empty", 64'(sb_q.size()), 64'd0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", dir_checks + mon_checks, dir_fail + mon_fail);
    $finish;
  end
endmodule
